// File: rtl/mnist_pkg.sv
// Shared constants and state encodings for the MNIST image path.
package mnist_pkg;

    localparam int unsigned IMG_BYTES = 784;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        LOAD      = 1'b1
    } ld_state_t;

endpackage

// File: rtl/uart_rx_8n1.sv
// Fixed-baud 8N1 receiver: 2-flop synchronizer, mid-bit sampling timer, LSB-first shifter.
module uart_rx_8n1 #(
    parameter int unsigned DIV = 868
) (
    input  logic       clk_100MHz,
    input  logic       reset_rtl_0,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);
    import mnist_pkg::*;

    localparam int unsigned   TW        = $clog2(DIV);
    localparam logic [TW-1:0] HALF_LOAD = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(DIV - 1);

    rx_state_t     state;
    logic          rxd_meta;
    logic          rxd_sync;
    logic          rxd_prev;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic          tick_c;

    assign tick_c = (timer == '0);

    always_ff @(posedge clk_100MHz or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
            state    <= R_IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (!tick_c) begin
                timer <= timer - TW'(1);
            end
            case (state)
                R_IDLE: begin
                    // Start bit edge: first sample lands mid start bit
                    if (rxd_prev && !rxd_sync) begin
                        timer <= HALF_LOAD;
                        state <= R_START;
                    end
                end
                R_START: begin
                    if (tick_c) begin
                        if (!rxd_sync) begin
                            timer   <= FULL_LOAD;
                            bit_cnt <= '0;
                            state   <= R_DATA;
                        end else begin
                            state <= R_IDLE;
                        end
                    end
                end
                R_DATA: begin
                    if (tick_c) begin
                        rx_byte <= {rxd_sync, rx_byte[7:1]};
                        timer   <= FULL_LOAD;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= R_STOP;
                        end
                    end
                end
                R_STOP: begin
                    if (tick_c) begin
                        rx_valid <= rxd_sync;
                        rx_ferr  <= !rxd_sync;
                        state    <= R_IDLE;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_image_loader.sv
// UART frame loader: waits for a sync byte, then writes IMG_BYTES pixels into the image BRAM.
module uart_image_loader #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned IMG_BYTES   = mnist_pkg::IMG_BYTES,
    parameter logic [7:0]  SYNC_BYTE   = mnist_pkg::SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    localparam int unsigned AW         = $clog2(IMG_BYTES)
) (
    input  logic          clk_100MHz,
    input  logic          reset_rtl_0,
    input  logic          uart_rxd,
    input  logic          accel_busy,
    output logic          img_we,
    output logic [AW-1:0] img_addr,
    output logic [7:0]    img_wdata,
    output logic          img_valid,
    output logic          loading,
    output logic          frame_abort
);
    import mnist_pkg::*;

    localparam int unsigned   DIV      = CLK_HZ / BAUD;
    localparam int unsigned   IW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW-1:0] LAST_PIX = AW'(IMG_BYTES - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ferr;
    ld_state_t     state;
    logic [AW-1:0] pix_cnt;
    logic [IW-1:0] idle_cnt;
    logic          frame_done;

    uart_rx_8n1 #(
        .DIV (DIV)
    ) u_rx (
        .clk_100MHz  (clk_100MHz),
        .reset_rtl_0 (reset_rtl_0),
        .rxd         (uart_rxd),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_ferr     (rx_ferr)
    );

    assign loading = (state == LOAD);

    // Loader FSM with pixel/idle counters; img_valid trails the final write by one cycle
    always_ff @(posedge clk_100MHz or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            state       <= WAIT_SYNC;
            pix_cnt     <= '0;
            idle_cnt    <= '0;
            frame_done  <= 1'b0;
            img_we      <= 1'b0;
            img_addr    <= '0;
            img_wdata   <= '0;
            img_valid   <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            img_we      <= 1'b0;
            frame_done  <= 1'b0;
            img_valid   <= frame_done;
            frame_abort <= 1'b0;
            case (state)
                WAIT_SYNC: begin
                    idle_cnt <= '0;
                    if (rx_valid && (rx_byte == SYNC_BYTE) && !accel_busy) begin
                        pix_cnt <= '0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (rx_valid) begin
                        img_we    <= 1'b1;
                        img_addr  <= pix_cnt;
                        img_wdata <= rx_byte;
                        idle_cnt  <= '0;
                        if (pix_cnt == LAST_PIX) begin
                            pix_cnt    <= '0;
                            frame_done <= 1'b1;
                            state      <= WAIT_SYNC;
                        end else begin
                            pix_cnt <= pix_cnt + AW'(1);
                        end
                    end else if (rx_ferr || (idle_cnt == IDLE_MAX)) begin
                        frame_abort <= 1'b1;
                        pix_cnt     <= '0;
                        idle_cnt    <= '0;
                        state       <= WAIT_SYNC;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                default: state <= WAIT_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_image_loader.sv
// Directed bench for uart_image_loader with a write scoreboard; small DIV and frame size keep runtime short.
module tb_uart_image_loader;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned DIV    = CLK_HZ / BAUD;
    localparam int unsigned NPIX   = 16;
    localparam int unsigned TMO    = 600;
    localparam int unsigned AW     = $clog2(NPIX);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rxd = 1'b1;
    logic          busy = 1'b0;
    logic          img_we;
    logic [AW-1:0] img_addr;
    logic [7:0]    img_wdata;
    logic          img_valid;
    logic          loading;
    logic          frame_abort;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int n_we = 0, n_valid = 0, n_abort = 0;
    int rxv_cnt = 0, ferr_cnt = 0;
    int last_we_cyc = 0, abort_cyc = 0, ferr_cyc = 0;
    logic abort_loading = 1'b0;
    int exp_we = 0, exp_valid = 0, exp_abort = 0;
    int exp_q[$];

    uart_image_loader #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .IMG_BYTES   (NPIX),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_100MHz  (clk),
        .reset_rtl_0 (rst_n),
        .uart_rxd    (rxd),
        .accel_busy  (busy),
        .img_we      (img_we),
        .img_addr    (img_addr),
        .img_wdata   (img_wdata),
        .img_valid   (img_valid),
        .loading     (loading),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Monitor: pops the scoreboard on every write and records pulse timing
    always @(negedge clk) begin
        int e;
        cyc++;
        if (dut.rx_valid) rxv_cnt++;
        if (dut.rx_ferr) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
        if (img_we) begin
            n_we++;
            last_we_cyc = cyc;
            chk("we_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("img_addr", 32'(img_addr), 32'(e >> 8));
                chk("img_wdata", 32'(img_wdata), 32'(e & 8'hFF));
            end
        end
        if (img_valid) begin
            n_valid++;
            chk("valid_latency", 32'(cyc - last_we_cyc), 32'd1);
        end
        if (frame_abort) begin
            n_abort++;
            abort_cyc = cyc;
            abort_loading = loading;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_pixel(input int addr, input logic [7:0] v);
        exp_q.push_back((addr << 8) | int'(v));
        exp_we++;
        send_byte(v, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] salt, input logic toggle_busy);
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < NPIX; i++) begin
            if (toggle_busy) busy = (i >= NPIX / 2);
            send_pixel(i, 8'(i) ^ salt);
        end
        busy = 1'b0;
        exp_valid++;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_we"}, 32'(n_we), 32'(exp_we));
        chk({tag, "_valid"}, 32'(n_valid), 32'(exp_valid));
        chk({tag, "_abort"}, 32'(n_abort), 32'(exp_abort));
        chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_loading"}, 32'(loading), 32'd0);
    endtask

    initial begin
        int rxv0;
        int ferr0;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(img_we), 32'd0);
        chk("rst_addr", 32'(img_addr), 32'd0);
        chk("rst_wdata", 32'(img_wdata), 32'd0);
        chk("rst_valid", 32'(img_valid), 32'd0);
        chk("rst_loading", 32'(loading), 32'd0);
        chk("rst_abort", 32'(frame_abort), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Plain frame, pixel = address
        send_frame(8'h00, 1'b0);
        check_counts("frame1");

        // Leading junk, then a frame containing 0xA5 as pixel data and busy toggled mid-frame
        send_byte(8'h00, 1'b1);
        send_byte(8'h5A, 1'b1);
        chk("junk_loading", 32'(loading), 32'd0);
        send_frame(8'hA1, 1'b1);
        check_counts("frame2");

        // Short low glitch while idle
        rxv0 = rxv_cnt;
        ferr0 = ferr_cnt;
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        chk("glitch_rx_valid", 32'(rxv_cnt), 32'(rxv0));
        chk("glitch_rx_ferr", 32'(ferr_cnt), 32'(ferr0));
        check_counts("glitch");

        // Framing error mid-frame aborts
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 10; i++) send_pixel(i, 8'(8'h30 + i));
        chk("pre_ferr_loading", 32'(loading), 32'd1);
        send_byte(8'hFF, 1'b0);
        exp_abort++;
        chk("ferr_abort_lat", 32'(abort_cyc - ferr_cyc), 32'd1);
        chk("ferr_loading_drop", 32'(abort_loading), 32'd0);
        check_counts("ferr");
        send_frame(8'h3C, 1'b0);
        check_counts("frame3");

        // Silence mid-frame times out
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 5; i++) send_pixel(i, 8'(8'hC0 | i));
        repeat (TMO + 50) @(negedge clk);
        exp_abort++;
        chk("timeout_lat", 32'(abort_cyc - last_we_cyc), 32'(TMO + 1));
        check_counts("timeout");

        // Sync ignored while accelerator busy
        busy = 1'b1;
        send_byte(8'hA5, 1'b1);
        busy = 1'b0;
        for (int i = 0; i < NPIX; i++) send_byte(8'(i), 1'b1);
        check_counts("busy");

        // Asynchronous reset mid-frame
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) send_pixel(i, 8'(8'h70 + i));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_addr", 32'(img_addr), 32'd0);
        chk("arst_wdata", 32'(img_wdata), 32'd0);
        chk("arst_loading", 32'(loading), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h07, 1'b1);
        check_counts("post_reset");
        send_frame(8'h55, 1'b0);
        check_counts("frame4");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
